// File: rtl/factor_display_scanner_if.sv
// Bus between the factorizer stage and the seven-segment scanner.
// Optional macro FACTOR_COUNT_EN adds the factor_count signal.
interface factor_display_scanner_if;
    logic [7:0] number;
    logic [7:0] factors;
    logic [7:0] segments;
    logic       digit_strobe;
    logic       busy;
`ifdef FACTOR_COUNT_EN
    logic [3:0] factor_count;
`endif

    modport master (
        output number,
        output factors,
        input  segments,
        input  digit_strobe,
`ifdef FACTOR_COUNT_EN
        input  factor_count,
`endif
        input  busy
    );

    modport slave (
        input  number,
        input  factors,
        output segments,
        output digit_strobe,
`ifdef FACTOR_COUNT_EN
        output factor_count,
`endif
        output busy
    );
endinterface

// File: rtl/factor_display_scanner.sv
// Waits for the factorizer to settle, latches its factor vector and scans the
// divisors 2..9 onto one seven-segment digit. Optional macro: FACTOR_COUNT_EN.
module factor_display_scanner #(
    parameter int DWELL_CYCLES  = 1000000,
    parameter int GAP_CYCLES    = 250000,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    factor_display_scanner_if.slave bus
);
    localparam int MAX_A = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int MAX_P = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);

    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {SETTLE, SHOW, GAP, DASH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       latched_q, latched_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       seg_q, seg_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic [3:0]       fc_q, fc_d;
    logic [2:0]       nidx;

    function automatic logic [7:0] seg_digit(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h5B;
            3'd1:    return 8'h4F;
            3'd2:    return 8'h66;
            3'd3:    return 8'h6D;
            3'd4:    return 8'h7D;
            3'd5:    return 8'h07;
            3'd6:    return 8'h7F;
            default: return 8'h6F;
        endcase
    endfunction

    // Searches upward from the bit after 'from', wrapping; 'from' itself is tried last.
    function automatic logic [2:0] next_set(input logic [7:0] v, input logic [2:0] from);
        logic [2:0] r;
        logic [2:0] p;
        logic       found;
        r     = from;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            p = from + 3'(k);
            if (!found && v[p]) begin
                r     = p;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int k = 0; k < 8; k++) s = s + 4'(v[k]);
        return s;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        latched_d = latched_q;
        last_d    = last_q;
        seg_d     = seg_q;
        strobe_d  = 1'b0;
        busy_d    = busy_q;
        fc_d      = fc_q;
        nidx      = idx_q;

        // A new number restarts everything, even on a terminal-count edge.
        if (bus.number != last_q) begin
            last_d  = bus.number;
            state_d = SETTLE;
            cnt_d   = SETTLE_LD;
            seg_d   = SEG_BLANK;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == '0) begin
                        latched_d = bus.factors;
                        busy_d    = 1'b0;
                        fc_d      = popcount(bus.factors);
                        strobe_d  = 1'b1;
                        if (bus.factors == 8'h00) begin
                            state_d = DASH;
                            seg_d   = SEG_DASH;
                        end else begin
                            nidx    = next_set(bus.factors, 3'd7);
                            idx_d   = nidx;
                            state_d = SHOW;
                            seg_d   = seg_digit(nidx);
                            cnt_d   = DWELL_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == '0) begin
                        seg_d   = SEG_BLANK;
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        nidx     = next_set(latched_q, idx_q);
                        idx_d    = nidx;
                        state_d  = SHOW;
                        seg_d    = seg_digit(nidx);
                        strobe_d = 1'b1;
                        cnt_d    = DWELL_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DASH:    ;
                default: state_d = SETTLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SETTLE;
            cnt_q     <= SETTLE_LD;
            idx_q     <= 3'd0;
            latched_q <= 8'h00;
            last_q    <= 8'h00;
            seg_q     <= SEG_BLANK;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b1;
            fc_q      <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            latched_q <= latched_d;
            last_q    <= last_d;
            seg_q     <= seg_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            fc_q      <= fc_d;
        end
    end

    assign bus.segments     = seg_q;
    assign bus.digit_strobe = strobe_q;
    assign bus.busy         = busy_q;
`ifdef FACTOR_COUNT_EN
    assign bus.factor_count = fc_q;
`else
    logic unused_fc;
    assign unused_fc = ^fc_q;
`endif
endmodule
